reservation_station: RTL and testbench
======================================

# reservation_station

Reservation station with an integral single-issue functional unit for the Tomasulo core. It sits directly upstream of the common data bus. It accepts issued instructions whose operands are either values or producer labels, snoops CDB broadcasts to resolve pending labels, and executes ready entries one at a time. It then holds each result and raises a bus request until the CDB arbiter grants it.

## Interface
Parameters:
- ENTRIES, 3: number of station entries; 1..8.
- BASE_LABEL, 1: label of entry 0; entry i owns label BASE_LABEL+i. Requires BASE_LABEL ≥ 1 and BASE_LABEL+ENTRIES-1 ≤ 15.
- LATENCY, 1: cycles from dispatch edge to first cycle with require high; ≥ 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- issue_valid  in  1  issue request this cycle.
- issue_op  in  2  operation: 00 add, 01 sub, 10 and, 11 or.
- issue_vj, issue_vk  in  32  operand values; meaningful when the matching q is 0.
- issue_qj, issue_qk  in  4  producer labels; 0 means the value is present.
- issue_ready  out  1  at least one free entry.
- issue_label  out  4  label of the entry the next issue will occupy; valid when issue_ready is high.
- cdb_en, cdb_label, cdb_data  in  1/4/32  CDB broadcast being snooped.
- require  out  1  result pending, bus requested.
- data_out  out  32  result value.
- label_out  out  4  label of the producing entry.
- accept  in  1  arbiter grant for this station.

## Operation
- Each entry holds: busy, op, vj, qj, vk, qk, and dispatched.
- Issue: on an edge with issue_valid & issue_ready, the lowest-index free entry is written and becomes busy. Issue with issue_ready low is ignored.
- Issue bypass: if cdb_en and a nonzero incoming q equals cdb_label on the issue edge, the entry stores cdb_data and q=0.
- Snoop: on every edge with cdb_en, each busy entry with a nonzero qj equal to cdb_label loads vj←cdb_data and qj←0. The same applies to qk/vk independently. Both operands may resolve on the same edge.
- Dispatch: the exec slot is free or being freed this edge (require & accept). The dispatch candidate is the lowest-index entry that is busy, not dispatched, and has qj=qk=0, evaluated on registered state. On dispatch:
  - the result is computed into the result register;
  - label_out ← BASE_LABEL+i;
  - the entry is marked dispatched;
  - the exec counter loads LATENCY-1.
- Exec: the counter decrements to 0. require = slot valid & counter==0.
- Completion: on an edge with require & accept:
  - the entry is freed (busy←0);
  - the slot is freed unless a new dispatch occurs on the same edge.
- The station also snoops its own broadcast; it has no internal forwarding path.
- Arithmetic: 32-bit, modulo 2^32. sub = vj−vk. Carry and overflow are discarded.
- accept while require is low is ignored.

## Timing
- Reset values:
  - all entries not busy;
  - exec slot empty;
  - require=0, data_out=0, label_out=0;
  - issue_ready=1, issue_label=BASE_LABEL.
- Asserting rst mid-operation clears all state immediately. require drops without waiting for accept.
- issue_ready and issue_label are combinational from registered busy bits. An entry freed on an edge is reusable from the following cycle.
- Fully ready issue at edge N dispatches at N+1. require is high from N+1+LATENCY−1 through the cycle of the accept edge.
- Data resolved by snoop at edge N allows dispatch at N+1 at the earliest.
- LATENCY=1 gives back-to-back throughput of one result per cycle under continuous accept.
- require, data_out, and label_out are stable while require is high and accept is low.
- Simultaneous issue, snoop, dispatch, and completion on one edge are all legal and independent. The entry freed is never the entry written.

## Structure
- Shared package holds:
  - LABEL_W=4 and DATA_W=32;
  - LABEL_NONE=4'd0;
  - opcode constants OP_ADD/OP_SUB/OP_AND/OP_OR;
  - the entry struct typedef.
- One sub-module: station_alu, a combinational op/vj/vk → result unit.
- Priority selects for the free entry and the ready entry are local functions.

## Test plan
- Reset then issue ADD vj=5, vk=7, q=0 → at the next cycle dispatch; require=1, data_out=12, label_out=1; accept → entry freed, issue_ready=1.
- Issue SUB qj=9, vk=3. Two cycles later, cdb_en with label 9, data 10 → dispatch follows. data_out=7. SUB 0−1 gives 0xFFFFFFFF.
- Issue 3 entries, none ready → issue_ready=0; a 4th issue is ignored. Free one via snoop + accept → issue_ready=1 next cycle, issue_label equals the freed label.
- Hold accept low for 5 cycles with require high → data_out and label_out stable. Dependent entry qj=1 resolves only when the external bus echoes label 1.
- Issue with qk=4 while cdb_en label 4 data 0xAA on the same edge → entry stored ready with vk=0xAA.
- Assert rst while require=1 and two entries busy → require=0 immediately, issue_ready=1, no stale result after release.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared types and constants for the reservation station and its ALU.
package reservation_station_pkg;

    localparam int LABEL_W = 4;
    localparam int DATA_W  = 32;

    localparam logic [LABEL_W-1:0] LABEL_NONE = 4'd0;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef struct packed {
        logic               busy;
        logic [1:0]         op;
        logic [DATA_W-1:0]  vj;
        logic [LABEL_W-1:0] qj;
        logic [DATA_W-1:0]  vk;
        logic [LABEL_W-1:0] qk;
        logic               dispatched;
    } rs_entry_t;

endpackage

// File: rtl/reservation_station_alu.sv
// Combinational integer unit: modulo-2^32 add/sub and bitwise and/or.
module station_alu
    import reservation_station_pkg::*;
(
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] vj,
    input  logic [DATA_W-1:0] vk,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = vj + vk;
            OP_SUB:  result = vj - vk;
            OP_AND:  result = vj & vk;
            default: result = vj | vk;
        endcase
    end

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station with a single-issue execution slot feeding the CDB.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int ENTRIES    = 3,
    parameter int BASE_LABEL = 1,
    parameter int LATENCY    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_valid,
    input  logic [1:0]         issue_op,
    input  logic [DATA_W-1:0]  issue_vj,
    input  logic [DATA_W-1:0]  issue_vk,
    input  logic [LABEL_W-1:0] issue_qj,
    input  logic [LABEL_W-1:0] issue_qk,
    output logic               issue_ready,
    output logic [LABEL_W-1:0] issue_label,
    input  logic               cdb_en,
    input  logic [LABEL_W-1:0] cdb_label,
    input  logic [DATA_W-1:0]  cdb_data,
    output logic               require,
    output logic [DATA_W-1:0]  data_out,
    output logic [LABEL_W-1:0] label_out,
    input  logic               accept
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CNT_W = $clog2(LATENCY + 1);

    // Returns {found, index} of the lowest set request bit.
    function automatic logic [IDX_W:0] pick_lowest(input logic [ENTRIES-1:0] req);
        logic [IDX_W:0] r;
        r = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (req[i]) r = {1'b1, IDX_W'(i)};
        end
        return r;
    endfunction

    rs_entry_t          ent [ENTRIES];
    logic               slot_vld;
    logic [CNT_W-1:0]   cnt;

    logic [ENTRIES-1:0] free_vec, rdy_vec;
    logic               free_any, rdy_any;
    logic [IDX_W-1:0]   free_idx, rdy_idx, done_idx;
    logic               done, dispatch, issue_fire;
    logic [DATA_W-1:0]  alu_result;
    rs_entry_t          new_ent;

    always_comb begin
        free_vec = '0;
        rdy_vec  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            free_vec[i] = ~ent[i].busy;
            rdy_vec[i]  = ent[i].busy && !ent[i].dispatched &&
                          (ent[i].qj == LABEL_NONE) && (ent[i].qk == LABEL_NONE);
        end
    end

    assign {free_any, free_idx} = pick_lowest(free_vec);
    assign {rdy_any, rdy_idx}   = pick_lowest(rdy_vec);

    assign issue_ready = free_any;
    assign issue_label = LABEL_W'(BASE_LABEL) + LABEL_W'(free_idx);
    assign issue_fire  = issue_valid && free_any;

    assign require  = slot_vld && (cnt == '0);
    assign done     = require && accept;
    assign dispatch = rdy_any && (!slot_vld || done);
    assign done_idx = IDX_W'(label_out - LABEL_W'(BASE_LABEL));

    station_alu u_alu (
        .op     (ent[rdy_idx].op),
        .vj     (ent[rdy_idx].vj),
        .vk     (ent[rdy_idx].vk),
        .result (alu_result)
    );

    // An operand broadcast on the issue edge would otherwise be missed forever.
    always_comb begin
        new_ent            = '0;
        new_ent.busy       = 1'b1;
        new_ent.op         = issue_op;
        new_ent.vj         = issue_vj;
        new_ent.qj         = issue_qj;
        new_ent.vk         = issue_vk;
        new_ent.qk         = issue_qk;
        new_ent.dispatched = 1'b0;
        if (cdb_en && issue_qj != LABEL_NONE && issue_qj == cdb_label) begin
            new_ent.vj = cdb_data;
            new_ent.qj = LABEL_NONE;
        end
        if (cdb_en && issue_qk != LABEL_NONE && issue_qk == cdb_label) begin
            new_ent.vk = cdb_data;
            new_ent.qk = LABEL_NONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) ent[i] <= '0;
            slot_vld  <= 1'b0;
            cnt       <= '0;
            data_out  <= '0;
            label_out <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (cdb_en && ent[i].busy) begin
                    if (ent[i].qj != LABEL_NONE && ent[i].qj == cdb_label) begin
                        ent[i].vj <= cdb_data;
                        ent[i].qj <= LABEL_NONE;
                    end
                    if (ent[i].qk != LABEL_NONE && ent[i].qk == cdb_label) begin
                        ent[i].vk <= cdb_data;
                        ent[i].qk <= LABEL_NONE;
                    end
                end
            end
            // Completed, dispatched and newly issued entries are always distinct.
            if (done)       ent[done_idx].busy       <= 1'b0;
            if (dispatch)   ent[rdy_idx].dispatched  <= 1'b1;
            if (issue_fire) ent[free_idx]            <= new_ent;

            if (dispatch) begin
                slot_vld  <= 1'b1;
                cnt       <= CNT_W'(LATENCY - 1);
                data_out  <= alu_result;
                label_out <= LABEL_W'(BASE_LABEL) + LABEL_W'(rdy_idx);
            end else if (done) begin
                slot_vld <= 1'b0;
            end else if (slot_vld && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed and randomized bench for reservation_station against a cycle-level behavioural model.
module tb_reservation_station;

    localparam int ENTRIES    = 3;
    localparam int BASE_LABEL = 1;
    localparam int LATENCY    = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [1:0]  issue_op = '0;
    logic [31:0] issue_vj = '0, issue_vk = '0;
    logic [3:0]  issue_qj = '0, issue_qk = '0;
    logic        issue_ready;
    logic [3:0]  issue_label;
    logic        cdb_en = 1'b0;
    logic [3:0]  cdb_label = '0;
    logic [31:0] cdb_data = '0;
    logic        require;
    logic [31:0] data_out;
    logic [3:0]  label_out;
    logic        accept = 1'b0;

    reservation_station #(
        .ENTRIES(ENTRIES), .BASE_LABEL(BASE_LABEL), .LATENCY(LATENCY)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_vj(issue_vj), .issue_vk(issue_vk),
        .issue_qj(issue_qj), .issue_qk(issue_qk),
        .issue_ready(issue_ready), .issue_label(issue_label),
        .cdb_en(cdb_en), .cdb_label(cdb_label), .cdb_data(cdb_data),
        .require(require), .data_out(data_out), .label_out(label_out),
        .accept(accept)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Behavioural model: entry table plus one execution slot.
    bit          m_busy [ENTRIES];
    bit          m_disp [ENTRIES];
    logic [1:0]  m_op   [ENTRIES];
    logic [31:0] m_vj   [ENTRIES];
    logic [31:0] m_vk   [ENTRIES];
    int          m_qj   [ENTRIES];
    int          m_qk   [ENTRIES];
    bit          m_slot;
    int          m_cnt;
    logic [31:0] m_data;
    int          m_label;

    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_busy[i] = 0; m_disp[i] = 0; m_op[i] = 0;
            m_vj[i] = 0; m_vk[i] = 0; m_qj[i] = 0; m_qk[i] = 0;
        end
        m_slot = 0; m_cnt = 0; m_data = 0; m_label = 0;
    endtask

    task automatic model_step();
        bit done;
        int fi;
        int ci;
        done = m_slot && (m_cnt == 0) && accept;
        fi = -1;
        ci = -1;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!m_busy[i] && fi < 0) fi = i;
            if (m_busy[i] && !m_disp[i] && m_qj[i] == 0 && m_qk[i] == 0 && ci < 0) ci = i;
        end
        if (cdb_en) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (m_busy[i] && m_qj[i] != 0 && m_qj[i] == int'(cdb_label)) begin
                    m_vj[i] = cdb_data; m_qj[i] = 0;
                end
                if (m_busy[i] && m_qk[i] != 0 && m_qk[i] == int'(cdb_label)) begin
                    m_vk[i] = cdb_data; m_qk[i] = 0;
                end
            end
        end
        if (done) m_busy[m_label - BASE_LABEL] = 0;
        if (ci >= 0 && (!m_slot || done)) begin
            m_data  = ref_alu(m_op[ci], m_vj[ci], m_vk[ci]);
            m_label = BASE_LABEL + ci;
            m_disp[ci] = 1;
            m_slot = 1;
            m_cnt  = LATENCY - 1;
        end else if (done) begin
            m_slot = 0;
        end else if (m_slot && m_cnt > 0) begin
            m_cnt--;
        end
        if (issue_valid && fi >= 0) begin
            m_busy[fi] = 1; m_disp[fi] = 0; m_op[fi] = issue_op;
            m_vj[fi] = issue_vj; m_qj[fi] = int'(issue_qj);
            m_vk[fi] = issue_vk; m_qk[fi] = int'(issue_qk);
            if (cdb_en && issue_qj != 0 && issue_qj == cdb_label) begin
                m_vj[fi] = cdb_data; m_qj[fi] = 0;
            end
            if (cdb_en && issue_qk != 0 && issue_qk == cdb_label) begin
                m_vk[fi] = cdb_data; m_qk[fi] = 0;
            end
        end
    endtask

    task automatic model_check();
        int fi;
        fi = -1;
        for (int i = 0; i < ENTRIES; i++) if (!m_busy[i] && fi < 0) fi = i;
        chk("require", 32'(require), 32'(m_slot && m_cnt == 0));
        chk("data_out", data_out, m_data);
        chk("label_out", 32'(label_out), 32'(m_label));
        chk("issue_ready", 32'(issue_ready), 32'(fi >= 0));
        if (fi >= 0) chk("issue_label", 32'(issue_label), 32'(BASE_LABEL + fi));
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        model_check();
    endtask

    task automatic do_issue(input logic [1:0] op, input logic [31:0] vj, input logic [3:0] qj,
                            input logic [31:0] vk, input logic [3:0] qk);
        issue_valid = 1'b1; issue_op = op;
        issue_vj = vj; issue_qj = qj; issue_vk = vk; issue_qk = qk;
    endtask

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_check();
        chk("rst_require", 32'(require), 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_label_out", 32'(label_out), 32'd0);
        chk("rst_issue_ready", 32'(issue_ready), 32'd1);
        chk("rst_issue_label", 32'(issue_label), 32'(BASE_LABEL));

        // ADD 5+7, fully ready
        do_issue(2'd0, 32'd5, 4'd0, 32'd7, 4'd0);
        cyc();
        issue_valid = 1'b0;
        cyc();
        chk("add_require", 32'(require), 32'd1);
        chk("add_data", data_out, 32'd12);
        chk("add_label", 32'(label_out), 32'd1);
        accept = 1'b1;
        cyc();
        accept = 1'b0;
        chk("add_freed_require", 32'(require), 32'd0);
        chk("add_freed_ready", 32'(issue_ready), 32'd1);
        chk("add_freed_label", 32'(issue_label), 32'd1);

        // SUB with qj resolved later by the bus
        do_issue(2'd1, 32'd0, 4'd9, 32'd3, 4'd0);
        cyc();
        issue_valid = 1'b0;
        cyc();
        cdb_en = 1'b1; cdb_label = 4'd9; cdb_data = 32'd10;
        cyc();
        cdb_en = 1'b0;
        chk("sub_wait_require", 32'(require), 32'd0);
        cyc();
        chk("sub_require", 32'(require), 32'd1);
        chk("sub_data", data_out, 32'd7);
        accept = 1'b1;
        cyc();
        accept = 1'b0;
        do_issue(2'd1, 32'd0, 4'd0, 32'd1, 4'd0);
        cyc();
        issue_valid = 1'b0;
        cyc();
        chk("sub_wrap_data", data_out, 32'hFFFF_FFFF);
        accept = 1'b1;
        cyc();
        accept = 1'b0;

        // Fill the station, then drain it
        do_issue(2'd0, 32'd0, 4'd9, 32'd1, 4'd0);
        repeat (3) cyc();
        chk("full_ready", 32'(issue_ready), 32'd0);
        do_issue(2'd0, 32'd77, 4'd0, 32'd0, 4'd0);
        cyc();
        issue_valid = 1'b0;
        chk("full_ignored_ready", 32'(issue_ready), 32'd0);
        chk("full_ignored_require", 32'(require), 32'd0);
        cdb_en = 1'b1; cdb_label = 4'd9; cdb_data = 32'd20;
        cyc();
        cdb_en = 1'b0;
        cyc();
        chk("drain_data", data_out, 32'd21);
        chk("drain_label", 32'(label_out), 32'd1);
        accept = 1'b1;
        cyc();
        chk("drain_freed_ready", 32'(issue_ready), 32'd1);
        chk("drain_freed_label", 32'(issue_label), 32'd1);
        chk("drain_b2b_label", 32'(label_out), 32'd2);
        chk("drain_b2b_require", 32'(require), 32'd1);
        cyc();
        cyc();
        accept = 1'b0;
        chk("drain_done_require", 32'(require), 32'd0);

        // Stall with accept low; dependent entry waits for the external echo
        do_issue(2'd0, 32'd100, 4'd0, 32'd1, 4'd0);
        cyc();
        do_issue(2'd0, 32'd0, 4'd1, 32'd0, 4'd0);
        cyc();
        issue_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_require", 32'(require), 32'd1);
            chk("stall_data", data_out, 32'd101);
            chk("stall_label", 32'(label_out), 32'd1);
            cyc();
        end
        accept = 1'b1;
        cyc();
        accept = 1'b0;
        cyc();
        chk("noecho_require", 32'(require), 32'd0);
        cdb_en = 1'b1; cdb_label = 4'd1; cdb_data = 32'd101;
        cyc();
        cdb_en = 1'b0;
        cyc();
        chk("echo_require", 32'(require), 32'd1);
        chk("echo_data", data_out, 32'd101);
        chk("echo_label", 32'(label_out), 32'd2);
        accept = 1'b1;
        cyc();
        accept = 1'b0;

        // Issue-edge bypass on qk
        do_issue(2'd0, 32'd1, 4'd0, 32'd0, 4'd4);
        cdb_en = 1'b1; cdb_label = 4'd4; cdb_data = 32'hAA;
        cyc();
        issue_valid = 1'b0; cdb_en = 1'b0;
        cyc();
        chk("bypass_require", 32'(require), 32'd1);
        chk("bypass_data", data_out, 32'hAB);
        accept = 1'b1;
        cyc();
        accept = 1'b0;

        // Asynchronous reset with a pending result and busy entries
        do_issue(2'd0, 32'd3, 4'd0, 32'd4, 4'd0);
        cyc();
        do_issue(2'd0, 32'd0, 4'd9, 32'd0, 4'd0);
        cyc();
        cyc();
        issue_valid = 1'b0;
        chk("prerst_require", 32'(require), 32'd1);
        chk("prerst_ready", 32'(issue_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst_require", 32'(require), 32'd0);
        chk("midrst_ready", 32'(issue_ready), 32'd1);
        chk("midrst_label_out", 32'(label_out), 32'd0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) cyc();
        chk("postrst_require", 32'(require), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            issue_valid = 1'($urandom_range(0, 1));
            issue_op    = 2'($urandom);
            issue_vj    = $urandom;
            issue_vk    = $urandom;
            issue_qj    = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            issue_qk    = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            cdb_en      = ($urandom_range(0, 9) < 4);
            if (require && $urandom_range(0, 1) == 1) begin
                cdb_label = label_out;
                cdb_data  = data_out;
            end else begin
                cdb_label = 4'($urandom_range(1, 15));
                cdb_data  = $urandom;
            end
            accept = ($urandom_range(0, 9) < 6);
            cyc();
        end
        issue_valid = 1'b0; cdb_en = 1'b0; accept = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
